// File: rtl/fc_score_layer.sv
// Final FC layer: MACs one feature per accepted cycle into all class accumulators, then emits biased, shifted, saturated scores.
// Latency: score 0 registered one edge after the last feature is taken; the remaining scores follow on consecutive edges.
// Backpressure: in_ready drops for the whole emit burst; the output side has no ready and must always absorb scores.
module fc_score_layer #(
    parameter int INPUT_BITS  = 12,
    parameter int WEIGHT_BITS = 8,
    parameter int NUM_INPUT   = 48,
    parameter int NUM_CLASS   = 10,
    parameter int ACC_BITS    = 26,
    parameter int SHIFT       = 4,
    parameter int OUTPUT_BITS = 12
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          valid_in,
    input  logic signed [INPUT_BITS-1:0]  data_in,
    output logic                          in_ready,
    input  logic                          w_we,
    input  logic [9:0]                    w_addr,
    input  logic signed [WEIGHT_BITS-1:0] w_data,
    output logic                          valid_out,
    output logic signed [OUTPUT_BITS-1:0] data_out
);
    localparam int NW   = NUM_CLASS * NUM_INPUT;
    localparam int WA_W = $clog2(NW);
    localparam int IW   = $clog2(NUM_INPUT);
    localparam int KW   = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1;
    localparam int PW   = INPUT_BITS + WEIGHT_BITS;

    typedef enum logic {ACCUM, EMIT} state_t;

    state_t                        state_q, state_d;
    logic [IW-1:0]                 idx_q, idx_d;
    logic [KW-1:0]                 k_q, k_d;
    logic                          valid_q, valid_d;
    logic signed [OUTPUT_BITS-1:0] data_q, data_d;
    logic signed [ACC_BITS-1:0]    acc_q [NUM_CLASS];
    logic signed [ACC_BITS-1:0]    acc_d [NUM_CLASS];

    // Parameter storage deliberately has no reset; software loads it before use.
    logic signed [WEIGHT_BITS-1:0] w_mem [NW];
    logic signed [WEIGHT_BITS-1:0] b_mem [NUM_CLASS];

    always_ff @(posedge clk) begin
        if (w_we) begin
            if (int'(w_addr) < NW)
                w_mem[WA_W'(w_addr)] <= w_data;
            else if (int'(w_addr) < NW + NUM_CLASS)
                b_mem[KW'(int'(w_addr) - NW)] <= w_data;
        end
    end

    logic [WA_W-1:0]     waddr [NUM_CLASS];
    logic signed [PW-1:0] prod [NUM_CLASS];

    always_comb begin
        for (int c = 0; c < NUM_CLASS; c++) begin
            waddr[c] = WA_W'(c * NUM_INPUT) + WA_W'(idx_q);
            prod[c]  = data_in * w_mem[waddr[c]];
        end
    end

    // One extra accumulator bit absorbs the bias add before the floor shift.
    logic signed [ACC_BITS:0]      sum_s, shifted;
    logic                          fits;
    logic signed [OUTPUT_BITS-1:0] sat;

    always_comb begin
        sum_s   = {acc_q[k_q][ACC_BITS-1], acc_q[k_q]}
                + {{(ACC_BITS+1-WEIGHT_BITS){b_mem[k_q][WEIGHT_BITS-1]}}, b_mem[k_q]};
        shifted = sum_s >>> SHIFT;
        fits    = (&shifted[ACC_BITS:OUTPUT_BITS-1]) | ~(|shifted[ACC_BITS:OUTPUT_BITS-1]);
        if (fits)
            sat = shifted[OUTPUT_BITS-1:0];
        else if (shifted[ACC_BITS])
            sat = {1'b1, {(OUTPUT_BITS-1){1'b0}}};
        else
            sat = {1'b0, {(OUTPUT_BITS-1){1'b1}}};
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        k_d     = k_q;
        valid_d = 1'b0;
        data_d  = data_q;
        acc_d   = acc_q;
        case (state_q)
            ACCUM: begin
                if (valid_in) begin
                    for (int c = 0; c < NUM_CLASS; c++)
                        acc_d[c] = acc_q[c] + {{(ACC_BITS-PW){prod[c][PW-1]}}, prod[c]};
                    if (idx_q == IW'(NUM_INPUT - 1)) begin
                        idx_d   = '0;
                        k_d     = '0;
                        state_d = EMIT;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            EMIT: begin
                valid_d = 1'b1;
                data_d  = sat;
                if (k_q == KW'(NUM_CLASS - 1)) begin
                    state_d = ACCUM;
                    k_d     = '0;
                    idx_d   = '0;
                    for (int c = 0; c < NUM_CLASS; c++)
                        acc_d[c] = '0;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            idx_q   <= '0;
            k_q     <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            for (int c = 0; c < NUM_CLASS; c++)
                acc_q[c] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            k_q     <= k_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            for (int c = 0; c < NUM_CLASS; c++)
                acc_q[c] <= acc_d[c];
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign valid_out = valid_q;
    assign data_out  = data_q;

endmodule

// File: tb/tb_fc_score_layer.sv
// Directed bench for fc_score_layer: two instances (SHIFT=0 and SHIFT=4) share all inputs.
module tb_fc_score_layer;
    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              valid_in = 1'b0;
    logic signed [11:0] data_in = '0;
    logic              w_we = 1'b0;
    logic [9:0]        w_addr = '0;
    logic signed [7:0] w_data = '0;
    logic              rdy0, rdy4, vo0, vo4;
    logic signed [11:0] do0, do4;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int q0[$];
    int q4[$];
    int qc[$];
    int e0[10];
    int e4[10];
    int last_cyc;
    int lowcnt;

    fc_score_layer #(.SHIFT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in), .in_ready(rdy0),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .valid_out(vo0), .data_out(do0)
    );
    fc_score_layer #(.SHIFT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in), .in_ready(rdy4),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .valid_out(vo4), .data_out(do4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) if (vo0) begin q0.push_back(int'(do0)); qc.push_back(cyc); end
    always @(negedge clk) if (vo4) q4.push_back(int'(do4));

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int d);
        w_we = 1'b1; w_addr = 10'(a); w_data = 8'(d);
        tick();
        w_we = 1'b0;
    endtask

    task automatic set_params(input int per_class, input int wv, input int b0, input int bstep);
        for (int c = 0; c < 10; c++)
            for (int i = 0; i < 48; i++)
                wr(c * 48 + i, (per_class != 0) ? (c - 5) : wv);
        for (int c = 0; c < 10; c++)
            wr(480 + c, b0 + bstep * c);
    endtask

    task automatic send(input int x);
        valid_in = 1'b1; data_in = 12'(x);
        tick();
        valid_in = 1'b0;
    endtask

    task automatic send_frame(input int ramp, input int xv, input int gaps);
        for (int i = 0; i < 48; i++) begin
            if (gaps != 0 && $urandom_range(0, 2) == 0)
                repeat ($urandom_range(1, 3)) tick();
            chk("rdy_in_frame", int'(rdy0), 1);
            send((ramp != 0) ? i + 1 : xv);
        end
        last_cyc = cyc;
    endtask

    task automatic clear_q();
        q0.delete(); q4.delete(); qc.delete();
    endtask

    task automatic wait_scores(input int n);
        for (int t = 0; t < 200 && q0.size() < n; t++) tick();
        repeat (3) tick();
    endtask

    task automatic check_scores(input string tag, input int t0, input int off);
        int g0, g4;
        for (int k = 0; k < 10; k++) begin
            g0 = (off + k < q0.size()) ? q0[off + k] : 99999;
            g4 = (off + k < q4.size()) ? q4[off + k] : 99999;
            chk({tag, "_s0"}, g0, e0[k]);
            chk({tag, "_s4"}, g4, e4[k]);
        end
        if (qc.size() >= off + 10) begin
            chk({tag, "_burst"}, qc[off + 9] - qc[off], 9);
            if (t0 >= 0) chk({tag, "_lat"}, qc[off] - t0, 1);
        end else begin
            chk({tag, "_count"}, qc.size(), off + 10);
        end
    endtask

    initial begin
        tick(); tick();
        chk("rst_vo", int'(vo0), 0);
        chk("rst_do", int'(do0), 0);
        chk("rst_rdy", int'(rdy0), 1);
        rst_n = 1'b1;
        tick();

        // Per-class weights, unit features
        set_params(1, 0, 0, 0);
        wr(1023, 55);
        e0 = '{-240, -192, -144, -96, -48, 0, 48, 96, 144, 192};
        e4 = '{-15, -12, -9, -6, -3, 0, 3, 6, 9, 12};
        clear_q();
        send_frame(0, 1, 0);
        wait_scores(10);
        chk("pc_size", q0.size(), 10);
        check_scores("pc", last_cyc, 0);

        // Reset after 20 features
        clear_q();
        for (int i = 0; i < 20; i++) send(1);
        rst_n = 1'b0;
        #1;
        chk("mf_vo", int'(vo0), 0);
        chk("mf_do", int'(do0), 0);
        chk("mf_rdy", int'(rdy0), 1);
        tick();
        rst_n = 1'b1;
        tick();
        send_frame(0, 1, 0);
        wait_scores(10);
        check_scores("mf", last_cyc, 0);

        // Reset after score 3
        clear_q();
        send_frame(0, 1, 0);
        for (int t = 0; t < 40 && q0.size() < 4; t++) tick();
        rst_n = 1'b0;
        #1;
        chk("me_vo", int'(vo0), 0);
        chk("me_do", int'(do0), 0);
        chk("me_rdy", int'(rdy0), 1);
        tick();
        rst_n = 1'b1;
        repeat (15) tick();
        chk("me_stop", q0.size(), 4);
        clear_q();
        send_frame(0, 1, 0);
        wait_scores(10);
        check_scores("me", last_cyc, 0);

        // Continuous valid_in across two frames
        clear_q();
        e0 = '{-1680, -1344, -1008, -672, -336, 0, 336, 672, 1008, 1344};
        e4 = '{-105, -84, -63, -42, -21, 0, 21, 42, 63, 84};
        valid_in = 1'b1; data_in = 12'sd7;
        for (int t = 0; t < 300 && q0.size() < 20; t++) tick();
        valid_in = 1'b0;
        tick();
        chk("bp_size", q0.size(), 20);
        check_scores("bp1", -1, 0);
        check_scores("bp2", -1, 10);
        if (qc.size() >= 11) chk("bp_period", qc[10] - qc[0], 58);
        else chk("bp_period_cnt", qc.size(), 20);
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();

        // Bias and shift with gaps
        set_params(0, 1, 0, 1);
        e0 = '{1176, 1177, 1178, 1179, 1180, 1181, 1182, 1183, 1184, 1185};
        e4 = '{73, 73, 73, 73, 73, 73, 73, 73, 74, 74};
        clear_q();
        send_frame(1, 0, 1);
        lowcnt = 0;
        for (int t = 0; t < 14; t++) begin
            if (!rdy0) lowcnt++;
            tick();
        end
        chk("bias_rdy_low", lowcnt, 10);
        chk("bias_size", q0.size(), 10);
        check_scores("bias", last_cyc, 0);

        // Positive then negative saturation
        set_params(0, 127, 127, 0);
        for (int k = 0; k < 10; k++) begin e0[k] = 2047; e4[k] = 2047; end
        clear_q();
        send_frame(0, 2047, 0);
        wait_scores(10);
        check_scores("satp", last_cyc, 0);
        for (int c = 0; c < 10; c++) wr(480 + c, -128);
        for (int k = 0; k < 10; k++) begin e0[k] = -2048; e4[k] = -2048; end
        clear_q();
        send_frame(0, -2048, 0);
        wait_scores(10);
        check_scores("satn", last_cyc, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
